// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encodings and sync pattern for the sequence-detector link
package seq_pkg;

    localparam logic [3:0] S_IDLE = 4'b0001;
    localparam logic [3:0] S_SYNC = 4'b0010;
    localparam logic [3:0] S_DATA = 4'b0100;
    localparam logic [3:0] S_GAP  = 4'b1000;

    // Sent MSB-first, so the line sees 0,1,0,1.
    localparam logic [3:0] SYNC_PATTERN = 4'b0101;

endpackage

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - MSB-first serial frame transmitter with idle-high line
// Optional SYNC preamble state enabled by macro SEQ_TX_SYNC_EN.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              dout,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    logic [3:0]        state;
    logic [3:0]        state_n;
    logic              dout_n;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              accept;
`ifdef SEQ_TX_SYNC_EN
    logic [3:0]        sync_sh;
    logic [1:0]        sync_cnt;
`endif

    assign accept     = (state == S_IDLE) && in_valid && in_ready;
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DATA) && (bit_cnt == LAST_BIT);

    // dout is registered, so dout_n is the bit the line shows after the next edge.
    always_comb begin
        state_n = state;
        dout_n  = 1'b1;
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef SEQ_TX_SYNC_EN
                    state_n = S_SYNC;
                    dout_n  = SYNC_PATTERN[3];
`else
                    state_n = S_DATA;
                    dout_n  = in_data[DATA_W-1];
`endif
                end
            end
`ifdef SEQ_TX_SYNC_EN
            S_SYNC: begin
                if (sync_cnt == 2'd3) begin
                    state_n = S_DATA;
                    dout_n  = shreg[DATA_W-1];
                end else begin
                    dout_n = sync_sh[2];
                end
            end
`endif
            S_DATA: begin
                if (bit_cnt == LAST_BIT) begin
                    state_n = (GAP_CYC > 0) ? S_GAP : S_IDLE;
                end else begin
                    dout_n = shreg[DATA_W-1];
                end
            end
            S_GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            dout     <= 1'b1;
            in_ready <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
`ifdef SEQ_TX_SYNC_EN
            sync_sh  <= '0;
            sync_cnt <= '0;
`endif
        end else begin
            state    <= state_n;
            dout     <= dout_n;
            in_ready <= (state_n == S_IDLE);

            // Without the preamble the MSB goes out on the accepting edge, so store pre-shifted.
            if (accept) begin
`ifdef SEQ_TX_SYNC_EN
                shreg <= in_data;
`else
                shreg <= in_data << 1;
`endif
            end else if (state_n == S_DATA) begin
                shreg <= shreg << 1;
            end

            if (state == S_DATA) begin
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                bit_cnt <= '0;
            end

            if (state == S_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end

`ifdef SEQ_TX_SYNC_EN
            if (accept) begin
                sync_sh <= SYNC_PATTERN;
            end else if (state == S_SYNC) begin
                sync_sh <= sync_sh << 1;
            end

            if (state == S_SYNC) begin
                sync_cnt <= sync_cnt + 1'b1;
            end else begin
                sync_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - directed bench for seq_pattern_tx (8-bit/gap 2 and 2-bit/gap 0 instances)
module tb_seq_pattern_tx;

`ifdef SEQ_TX_SYNC_EN
    localparam int SN = 4;
`else
    localparam int SN = 0;
`endif
    localparam int FL  = SN + 8;
    localparam int FL2 = SN + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, dout, busy, frame_done;
    logic       in_valid2 = 1'b0;
    logic [1:0] in_data2 = 2'b00;
    logic       in_ready2, dout2, busy2, frame_done2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] word;
        logic [7:0] bits;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    seq_pattern_tx #(.DATA_W(8), .GAP_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .dout(dout), .busy(busy), .frame_done(frame_done)
    );

    seq_pattern_tx #(.DATA_W(2), .GAP_CYC(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .dout(dout2), .busy(busy2), .frame_done(frame_done2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] w, input logic [7:0] bits);
        logic [3:0] sp = 4'b0101;
        wait_ready();
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~w;
        for (int i = 0; i < SN; i++) begin
            chk("sync_bit", {31'd0, dout}, {31'd0, sp[3-i]});
            chk("sync_busy", {29'd0, busy, in_ready, frame_done}, 32'b100);
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            chk("data_bit", {31'd0, dout}, {31'd0, bits[7-i]});
            chk("data_fd", {31'd0, frame_done}, (i == 7) ? 32'd1 : 32'd0);
            chk("data_busy", {30'd0, busy, in_ready}, 32'b10);
            @(negedge clk);
        end
        for (int g = 0; g < 2; g++) begin
            chk("gap_line", {28'd0, dout, busy, in_ready, frame_done}, 32'b1100);
            @(negedge clk);
        end
        chk("idle_after", {29'd0, dout, busy, in_ready}, 32'b101);
    endtask

    initial begin
        logic       exp_s [$];
        logic       exp_s2 [$];
        logic [3:0] sp = 4'b0101;
        logic [7:0] w2 = 8'b1000_0001;
        logic [1:0] d2 = 2'b01;
        int         fd_cnt;

        vecs[0] = '{8'hA5, 8'b1010_0101};
        vecs[1] = '{8'hFF, 8'b1111_1111};
        vecs[2] = '{8'h00, 8'b0000_0000};
        vecs[3] = '{8'h81, 8'b1000_0001};
        vecs[4] = '{8'h3C, 8'b0011_1100};
        vecs[5] = '{8'h5A, 8'b0101_1010};
        vecs[6] = '{8'h01, 8'b0000_0001};
        vecs[7] = '{8'h80, 8'b1000_0000};

        // Reset state and first ready edge
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) @(negedge clk);
        chk("rst_out", {28'd0, dout, in_ready, busy, frame_done}, 32'b1000);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("first_ready", {30'd0, in_ready, busy}, 32'b10);
        in_valid = 1'b0;
        @(negedge clk);

        // Table-driven frames
        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].word, vecs[v].bits);
        end

        // Back-to-back: 00 then 81 with in_valid held high
        for (int i = 0; i < SN; i++) exp_s.push_back(sp[3-i]);
        for (int i = 0; i < 8; i++)  exp_s.push_back(1'b0);
        for (int i = 0; i < 3; i++)  exp_s.push_back(1'b1);
        for (int i = 0; i < SN; i++) exp_s.push_back(sp[3-i]);
        for (int i = 0; i < 8; i++)  exp_s.push_back(w2[7-i]);
        for (int i = 0; i < 3; i++)  exp_s.push_back(1'b1);
        wait_ready();
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(negedge clk);
        in_data = 8'h81;
        fd_cnt  = 0;
        for (int i = 0; i < exp_s.size(); i++) begin
            if (i == FL + 3) in_valid = 1'b0;
            chk("b2b_bit", {31'd0, dout}, {31'd0, exp_s[i]});
            if (frame_done) fd_cnt++;
            @(negedge clk);
        end
        chk("b2b_frames", fd_cnt, 32'd2);
        chk("b2b_idle", {30'd0, in_ready, busy}, 32'b10);

        // Reset mid-frame at payload bit 3
        wait_ready();
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        fd_cnt   = 0;
        for (int i = 0; i < SN + 3; i++) begin
            if (frame_done) fd_cnt++;
            @(negedge clk);
        end
        chk("mid_bit3", {31'd0, dout}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_async", {28'd0, dout, busy, in_ready, frame_done}, 32'b1000);
        for (int i = 0; i < 10; i++) begin
            if (frame_done) fd_cnt++;
            @(negedge clk);
        end
        chk("mid_no_fd", fd_cnt, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(8'h3C, 8'b0011_1100);

        // DATA_W=2, GAP_CYC=0 instance: single idle one, accept on that cycle
        for (int i = 0; i < SN; i++) exp_s2.push_back(sp[3-i]);
        exp_s2.push_back(d2[1]);
        exp_s2.push_back(d2[0]);
        exp_s2.push_back(1'b1);
        for (int i = 0; i < SN; i++) exp_s2.push_back(sp[3-i]);
        exp_s2.push_back(d2[1]);
        chk("w2_ready", {31'd0, in_ready2}, 32'd1);
        in_valid2 = 1'b1;
        in_data2  = 2'b01;
        @(negedge clk);
        for (int i = 0; i < exp_s2.size(); i++) begin
            if (i == FL2 + 1) in_valid2 = 1'b0;
            chk("w2_bit", {31'd0, dout2}, {31'd0, exp_s2[i]});
            chk("w2_fd", {31'd0, frame_done2}, (i == FL2 - 1) ? 32'd1 : 32'd0);
            if (i == FL2) chk("w2_idle", {30'd0, busy2, in_ready2}, 32'b01);
            if (i == FL2 + 1) chk("w2_reaccept", {31'd0, busy2}, 32'd1);
            @(negedge clk);
        end
        repeat (SN + 4) @(negedge clk);
        chk("w2_done", {30'd0, in_ready2, dout2}, 32'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
